// File: rtl/cfs_md_responder_if.sv
// MD bus interface: one master-to-responder transfer channel.
//   md_valid  - master transfer request
//   md_data   - transfer data, DATA_WIDTH bits
//   md_offset - byte offset of the first valid byte
//   md_size   - number of valid bytes
//   md_ready  - responder completes the transfer (valid & ready)
//   md_err    - error response, meaningful only while md_ready is high
interface cfs_md_responder_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int B  = DATA_WIDTH / 8;
  localparam int OW = (B > 1) ? $clog2(B) : 1;
  localparam int SW = $clog2(B) + 1;

  logic                  md_valid;
  logic [DATA_WIDTH-1:0] md_data;
  logic [OW-1:0]         md_offset;
  logic [SW-1:0]         md_size;
  logic                  md_ready;
  logic                  md_err;

  modport master (
    output md_valid, md_data, md_offset, md_size,
    input  md_ready, md_err
  );

  modport slave (
    input  md_valid, md_data, md_offset, md_size,
    output md_ready, md_err
  );
endinterface

// File: rtl/cfs_md_responder.sv
// MD-protocol responder (slave end of the MD bus).
// Accepts a transfer, waits wait_cycles, then answers with a one-cycle
// md_ready (md_err for illegal transfers). Legal transfers are pushed into a
// first-word fall-through FIFO for downstream logic.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   md                - MD bus, slave modport
//   wait_cycles       - wait states before ready, sampled in IDLE
//   out_valid/ready   - FIFO head handshake; out_data/offset/size = head
//   fifo_level        - occupied FIFO entries
//   err_cnt           - saturating count of error responses
//   protocol_err      - sticky master protocol violation
//
// Build option: define CFS_MD_RESP_PROTOCOL_CHECK_EN to check that the master
// holds md_valid and its payload stable while a transfer is waiting.
// Without it protocol_err is tied low.
//
// state  | meaning
// S_IDLE | no transfer outstanding; capture wait count and legality
// S_WAIT | counting wait states, or stalled on a full FIFO
// S_RESP | md_ready high for one cycle; push or count error
module cfs_md_responder #(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 4,
  parameter  int WAIT_WIDTH = 4,
  localparam int B  = DATA_WIDTH / 8,
  localparam int OW = (B > 1) ? $clog2(B) : 1,
  localparam int SW = $clog2(B) + 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  cfs_md_responder_if.slave     md,
  input  logic [WAIT_WIDTH-1:0] wait_cycles,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OW-1:0]         out_offset,
  output logic [SW-1:0]         out_size,
  output logic [LW-1:0]         fifo_level,
  output logic [15:0]           err_cnt,
  output logic                  protocol_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [OW-1:0]         offset;
    logic [SW-1:0]         size;
  } entry_t;

  state_t                state;
  logic [WAIT_WIDTH-1:0] cnt;
  logic                  legal_q;
  logic                  legal;
  logic [EW-1:0]         end_byte;
  logic                  push;
  logic                  pop;
  logic                  fifo_room;
  entry_t                mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // One extra bit so offset + size cannot wrap.
  assign end_byte = EW'(md.md_offset) + EW'(md.md_size);
  assign legal    = (md.md_size != '0) && (end_byte <= EW'(B));

  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid & out_ready;
  assign push      = (state == S_RESP) & legal_q;
  // A pop in the decision cycle frees the slot the coming push needs.
  assign fifo_room = (fifo_level < LW'(FIFO_DEPTH)) | pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      legal_q     <= 1'b0;
      md.md_ready <= 1'b0;
      md.md_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      md.md_ready <= 1'b0;
      md.md_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md.md_valid) begin
            cnt     <= wait_cycles;
            legal_q <= legal;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!md.md_valid) begin
            state <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - WAIT_WIDTH'(1);
          end else if (!legal_q || fifo_room) begin
            state       <= S_RESP;
            md.md_ready <= 1'b1;
            md.md_err   <= !legal_q;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          if (!legal_q && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{data: md.md_data, offset: md.md_offset, size: md.md_size};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign {out_data, out_offset, out_size} = mem[rd_ptr];

`ifdef CFS_MD_RESP_PROTOCOL_CHECK_EN
  logic [DATA_WIDTH-1:0] data_q;
  logic [OW-1:0]         offset_q;
  logic [SW-1:0]         size_q;
  logic                  prot_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      offset_q <= '0;
      size_q   <= '0;
      prot_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && md.md_valid) begin
        data_q   <= md.md_data;
        offset_q <= md.md_offset;
        size_q   <= md.md_size;
      end
      if (state == S_WAIT &&
          (!md.md_valid || md.md_data != data_q ||
           md.md_offset != offset_q || md.md_size != size_q)) begin
        prot_q <= 1'b1;
      end
    end
  end

  assign protocol_err = prot_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfs_md_responder.sv
module tb_cfs_md_responder;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int WW    = 4;
`ifdef CFS_MD_RESP_PROTOCOL_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [WW-1:0] wait_cycles;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_offset;
  logic [2:0]    out_size;
  logic [2:0]    fifo_level;
  logic [15:0]   err_cnt;
  logic          protocol_err;

  cfs_md_responder_if #(.DATA_WIDTH(DW)) md_bus ();

  cfs_md_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .WAIT_WIDTH(WW)) dut (
    .clk(clk), .reset(reset), .md(md_bus), .wait_cycles(wait_cycles),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_offset(out_offset), .out_size(out_size), .fifo_level(fifo_level),
    .err_cnt(err_cnt), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: a queue of accepted payloads, the cycle from
  // which the outstanding transfer may complete, and its legality.
  typedef struct {
    logic [31:0] d;
    logic [1:0]  o;
    logic [2:0]  s;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          m_errs = 0;
  int          m_earliest = 0;
  bit          m_active = 0;
  bit          m_legal = 0;
  bit          m_prot = 0;
  bit          room_prev = 1;
  logic [31:0] m_data0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] o, input logic [2:0] s);
    return (s != 0) && (int'(o) + int'(s) <= DW / 8);
  endfunction

  function automatic bit model_ready();
    return m_active && (cyc >= m_earliest) && (!m_legal || room_prev);
  endfunction

  // Called at a falling edge: checks this cycle's outputs, then advances the
  // model by the events at the next rising edge using the inputs now driven.
  task automatic tick();
    bit   rdy;
    bit   pop;
    bit   nroom;
    ent_t e;
    rdy = model_ready();
    chk("md_ready", md_bus.md_ready, rdy);
    chk("md_err", md_bus.md_err, rdy && !m_legal);
    chk("fifo_level", fifo_level, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_offset", out_offset, q[0].o);
      chk("out_size", out_size, q[0].s);
    end
    chk("err_cnt", err_cnt, m_errs);
    chk("protocol_err", protocol_err, m_prot);
    pop   = (q.size() != 0) && out_ready;
    nroom = (q.size() < DEPTH) || pop;
    if (reset) begin
      q.delete();
      m_errs    = 0;
      m_active  = 0;
      m_prot    = 0;
      room_prev = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (rdy) begin
        if (m_legal) begin
          e.d = md_bus.md_data;
          e.o = md_bus.md_offset;
          e.s = md_bus.md_size;
          q.push_back(e);
        end else if (m_errs < 65535) begin
          m_errs++;
        end
        m_active = 0;
      end else if (m_active) begin
        if (!md_bus.md_valid) begin
          m_active = 0;
          if (PCHK) m_prot = 1;
        end else if (PCHK && (md_bus.md_data !== m_data0)) begin
          m_prot = 1;
        end
      end else if (md_bus.md_valid) begin
        m_active   = 1;
        m_earliest = cyc + 2 + int'(wait_cycles);
        m_legal    = is_legal(md_bus.md_offset, md_bus.md_size);
        m_data0    = md_bus.md_data;
      end
      room_prev = nroom;
    end
    cyc++;
    @(negedge clk);
  endtask

  // One transfer; pop_at >= 0 pulses out_ready on that cycle of the transfer.
  task automatic xfer(input logic [31:0] d, input logic [1:0] o, input logic [2:0] s,
                      input int w, input int pop_at, input int exp_lat, input string tag);
    int t0;
    int lat;
    t0  = cyc;
    lat = -1;
    md_bus.md_valid  = 1'b1;
    md_bus.md_data   = d;
    md_bus.md_offset = o;
    md_bus.md_size   = s;
    wait_cycles      = WW'(w);
    for (int i = 0; i < 64 && lat < 0; i++) begin
      if (pop_at >= 0) out_ready = (i == pop_at);
      if (i > 0) wait_cycles = WW'($urandom);
      if (md_bus.md_ready) lat = cyc - t0;
      tick();
    end
    md_bus.md_valid = 1'b0;
    if (pop_at >= 0) out_ready = 1'b0;
    chk(tag, lat, exp_lat);
  endtask

  // Transfer with wait=3 where the master either changes data or drops valid.
  task automatic prot_xfer(input bit drop, input string tag);
    int t0;
    int lat;
    t0  = cyc;
    lat = -1;
    md_bus.md_valid  = 1'b1;
    md_bus.md_data   = $urandom;
    md_bus.md_offset = 2'd0;
    md_bus.md_size   = 3'd4;
    wait_cycles      = WW'(3);
    for (int i = 0; i < 12 && lat < 0; i++) begin
      if (i == 2) begin
        if (drop) md_bus.md_valid = 1'b0;
        else      md_bus.md_data  = ~md_bus.md_data;
      end
      if (md_bus.md_ready) lat = cyc - t0;
      tick();
    end
    md_bus.md_valid = 1'b0;
    chk(tag, lat, drop ? -1 : 5);
  endtask

  initial begin
    int lvl;
    bit busy;
    bit done;
    int busy_cnt;

    reset            = 1'b1;
    md_bus.md_valid  = 1'b0;
    md_bus.md_data   = '0;
    md_bus.md_offset = '0;
    md_bus.md_size   = '0;
    wait_cycles      = '0;
    out_ready        = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", md_bus.md_ready, 0);
    chk("rst_level", fifo_level, 0);

    // Legal transfer, no wait states.
    xfer(32'hA5A5_1234, 2'd1, 3'd2, 0, -1, 2, "lat_legal");
    chk("head_valid", out_valid, 1);
    chk("head_data", out_data, 32'hA5A5_1234);
    chk("head_offset", out_offset, 1);
    chk("head_size", out_size, 2);
    chk("head_level", fifo_level, 1);

    // Illegal transfers: overflowing span, then zero size.
    xfer(32'h1111_2222, 2'd3, 3'd2, 3, -1, 5, "lat_illegal_span");
    xfer(32'h3333_4444, 2'd0, 3'd0, 3, -1, 5, "lat_illegal_zero");
    chk("illegal_err_cnt", err_cnt, 2);
    chk("illegal_no_push", fifo_level, 1);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    // Fill the FIFO, then stall the fifth transfer until a single pop.
    for (int k = 0; k < DEPTH; k++) xfer($urandom, 2'd0, 3'd4, 0, -1, 2, "lat_fill");
    xfer($urandom, 2'd0, 3'd4, 0, 6, 7, "lat_stall");
    chk("full_level", fifo_level, 4);

    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    out_ready = 1'b0;

    // Reset while counting wait states.
    md_bus.md_valid  = 1'b1;
    md_bus.md_data   = 32'hDEAD_BEEF;
    md_bus.md_offset = 2'd0;
    md_bus.md_size   = 3'd4;
    wait_cycles      = WW'(7);
    for (int k = 0; k < 4; k++) tick();
    reset           = 1'b1;
    md_bus.md_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_level", fifo_level, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    xfer(32'h0BAD_F00D, 2'd2, 3'd2, 1, -1, 3, "lat_after_rst");

    // Master protocol violations.
    prot_xfer(1'b0, "lat_data_change");
    chk("prot_after_change", protocol_err, PCHK);
    lvl = fifo_level;
    prot_xfer(1'b1, "lat_valid_drop");
    chk("drop_no_push", fifo_level, lvl);
    chk("prot_after_drop", protocol_err, PCHK);
    xfer(32'h5555_AAAA, 2'd0, 3'd1, 0, -1, 2, "lat_after_prot");
    chk("prot_sticky", protocol_err, PCHK);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("prot_cleared", protocol_err, 0);

    // Randomized traffic against the reference model.
    busy     = 0;
    busy_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!busy && $urandom_range(0, 2) == 0) begin
        busy             = 1;
        busy_cnt         = 0;
        md_bus.md_valid  = 1'b1;
        md_bus.md_data   = $urandom;
        md_bus.md_offset = 2'($urandom_range(0, 3));
        md_bus.md_size   = 3'($urandom_range(0, 5));
        wait_cycles      = WW'($urandom_range(0, 5));
      end else if (busy) begin
        wait_cycles = WW'($urandom);
        busy_cnt++;
      end
      out_ready = ($urandom_range(0, 2) == 0);
      done = busy && md_bus.md_ready;
      tick();
      if (done) begin
        busy            = 0;
        md_bus.md_valid = 1'b0;
      end else if (busy && busy_cnt > 100) begin
        chk("xfer_done", md_bus.md_ready, 1);
        busy            = 0;
        md_bus.md_valid = 1'b0;
      end
    end
    md_bus.md_valid = 1'b0;
    out_ready       = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
